receptor_ps2: RTL
=================

// Module: receptor_ps2
// PURPOSE
//  PS/2 keyboard front end. Samples raw ps2c/ps2d, de-glitches the keyboard clock, and deframes 11-bit frames
//  (start, 8 data LSB-first, odd parity, stop). Drops break (F0+code) and extended-prefix (E0) bytes and suppresses
//  typematic repeats. Sits directly upstream of the data-capture stage; drives its Dato/Tick inputs.
// PARAMETERS
//  FILTER_LEN   8       consecutive equal samples needed to change filtered ps2c level (>=2)
//  TIMEOUT_CYC  100000  clk cycles without a falling edge inside a frame before abort (2 ms @ 50 MHz)
// PORTS
//  clk    in   1  system clock
//  rst    in   1  reset, asynchronous, active-low (0 = reset)
//  ps2c   in   1  raw PS/2 clock from connector, asynchronous
//  ps2d   in   1  raw PS/2 data from connector, asynchronous
//  dato   out  8  last accepted make code; holds until the next accepted code
//  tick   out  1  one-cycle pulse: dato holds a new make code (same cycle)
//  err    out  1  one-cycle pulse on parity error, stop-bit error or timeout
//  busy   out  1  high while a frame is being received (state RECV/CHECK)
// BEHAVIOUR
//  Reset (rst=0, async): dato=8'h00, tick=0, err=0, busy=0, FSM=IDLE, brk=0, held=0, last_make=8'h00,
//   bit count=0, timeout counter=0, filter shift register=all 1, filtered ps2c=1.
//  Input sync: ps2c and ps2d each pass through 2 flip-flops before any use.
//  Filter: FILTER_LEN-bit shift register of synced ps2c. Filtered level -> 1 when all bits 1, -> 0 when all bits 0,
//   otherwise holds. fall = filtered 1->0, one-cycle pulse. ps2d is sampled (synced) in the cycle of fall.
//  FSM IDLE/RECV/CHECK:
//   IDLE : on fall with ps2d=0 (start bit) -> RECV, bit count=0. fall with ps2d=1 is ignored.
//   RECV : each fall shifts ps2d into a 10-bit frame register (data[7:0], parity, stop), bit count+1.
//          When the 10th bit is captured -> CHECK. Timeout counter clears on every fall and increments otherwise;
//          reaching TIMEOUT_CYC-1 -> IDLE, err pulse, brk cleared, frame discarded.
//   CHECK: one cycle, always -> IDLE. frame_ok = (^{data,parity} == 1) && stop == 1.
//  Code handling in CHECK (only if frame_ok):
//   data==F0 -> brk=1, no tick.  data==E0 -> no tick, flags unchanged (the next byte is handled as a normal code).
//   brk=1 -> release: brk=0; if data==last_make then held=0; no tick.
//   else data==last_make && held==1 -> typematic repeat, no tick.
//   else -> dato=data, last_make=data, held=1, tick=1.
//  !frame_ok in CHECK -> err pulse, brk=0, no tick, dato unchanged.
//  Latency: tick/err register high in the cycle after CHECK, i.e. exactly 2 clk after the fall pulse of the stop bit.
//  tick and err are never high together. Each is 1 cycle wide.
//  busy = 1 in RECV and CHECK, registered with the state.
//  rst asserted mid-frame: everything returns to reset values immediately; a partial frame is lost.
//   The first fall after reset release starts a new frame only if ps2d=0.
// TESTING
//  1 reset; frame 0x16, parity 0, stop 1 (12 kHz ps2c) -> one tick, dato=8'h16, err=0, busy falls after CHECK.
//  2 frames 16, F0, 16 -> exactly one tick (dato=16). Then 16 again -> second tick, dato=16.
//  3 frames 1C, 1C, 1C (typematic), F0, 1C -> one tick only. Frame 45 in between resets the repeat state:
//    1C, 45, 1C -> three ticks.
//  4 frame 0x16 with parity=1 -> err pulse 2 clk after stop fall, no tick, dato keeps previous value.
//    Frame with stop=0 -> err.
//  5 glitch on ps2c of FILTER_LEN-1 cycles during IDLE and RECV -> no state change and no extra bit.
//    Stop ps2c after 4 bits for TIMEOUT_CYC cycles -> err, busy=0. Next valid frame 0x25 -> tick, dato=25.
//  6 rst=0 for 3 cycles in the middle of a frame (after 5 bits) -> dato=0, tick=0, err=0, busy=0 at once.
//    Complete frame 0x1E after release -> tick, dato=1E.

Source files
------------

// File: rtl/receptor_ps2_if.sv
// PS/2 receiver bundle: raw keyboard lines in, decoded make code, tick, err and busy out.
interface receptor_ps2_if;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] dato;
    logic       tick;
    logic       err;
    logic       busy;

    modport master (output ps2c, output ps2d, input dato, input tick, input err, input busy);
    modport slave  (input ps2c, input ps2d, output dato, output tick, output err, output busy);
endinterface

// File: rtl/receptor_ps2.sv
// PS/2 keyboard front end: syncs and de-glitches ps2c, deframes 11-bit frames, and forwards only
// fresh make codes (break, E0 prefix and typematic repeats are swallowed).
module receptor_ps2 #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic           clk,
    input  logic           rst,
    receptor_ps2_if.slave  ps2
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [1:0]            r_ps2cSync, r_ps2dSync;
    logic [FILTER_LEN-1:0] r_filt;
    logic                  r_ps2cFilt;
    logic                  w_fall, w_ps2dBit, w_frameOk;
    state_t                r_state, w_stateNext;
    logic [3:0]            r_bitCnt, w_bitCntNext;
    logic [9:0]            r_frame, w_frameNext;
    logic [TW-1:0]         r_toCnt, w_toCntNext;
    logic                  r_brk, w_brkNext, r_held, w_heldNext;
    logic [7:0]            r_lastMake, w_lastMakeNext, r_dato, w_datoNext;
    logic                  r_tick, w_tickNext, r_err, w_errNext, r_busy;

    // Filtered level only moves once the whole window agrees, so short spikes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ps2cSync <= 2'b11;
            r_ps2dSync <= 2'b11;
            r_filt     <= '1;
            r_ps2cFilt <= 1'b1;
        end else begin
            r_ps2cSync <= {r_ps2cSync[0], ps2.ps2c};
            r_ps2dSync <= {r_ps2dSync[0], ps2.ps2d};
            r_filt     <= {r_filt[FILTER_LEN-2:0], r_ps2cSync[1]};
            if (&r_filt)
                r_ps2cFilt <= 1'b1;
            else if (~|r_filt)
                r_ps2cFilt <= 1'b0;
        end
    end

    assign w_fall    = r_ps2cFilt && (r_filt == '0);
    assign w_ps2dBit = r_ps2dSync[1];
    assign w_frameOk = (^r_frame[8:0]) && r_frame[9];

    always_comb begin
        w_stateNext    = r_state;
        w_bitCntNext   = r_bitCnt;
        w_frameNext    = r_frame;
        w_toCntNext    = r_toCnt;
        w_brkNext      = r_brk;
        w_heldNext     = r_held;
        w_lastMakeNext = r_lastMake;
        w_datoNext     = r_dato;
        w_tickNext     = 1'b0;
        w_errNext      = 1'b0;
        case (r_state)
            IDLE: begin
                w_toCntNext = '0;
                if (w_fall && !w_ps2dBit) begin
                    w_stateNext  = RECV;
                    w_bitCntNext = 4'd0;
                end
            end
            RECV: begin
                if (w_fall) begin
                    w_frameNext  = {w_ps2dBit, r_frame[9:1]};
                    w_bitCntNext = r_bitCnt + 4'd1;
                    w_toCntNext  = '0;
                    if (r_bitCnt == 4'd9)
                        w_stateNext = CHECK;
                end else if (r_toCnt == TW'(TIMEOUT_CYC - 1)) begin
                    w_stateNext = IDLE;
                    w_errNext   = 1'b1;
                    w_brkNext   = 1'b0;
                end else begin
                    w_toCntNext = r_toCnt + TW'(1);
                end
            end
            CHECK: begin
                w_stateNext = IDLE;
                if (!w_frameOk) begin
                    w_errNext = 1'b1;
                    w_brkNext = 1'b0;
                end else if (r_frame[7:0] == 8'hF0) begin
                    w_brkNext = 1'b1;
                end else if (r_frame[7:0] == 8'hE0) begin
                    w_brkNext = r_brk;
                end else if (r_brk) begin
                    // Release of the held key re-arms it so the next press is reported again.
                    w_brkNext = 1'b0;
                    if (r_frame[7:0] == r_lastMake)
                        w_heldNext = 1'b0;
                end else if (!(r_frame[7:0] == r_lastMake && r_held)) begin
                    w_datoNext     = r_frame[7:0];
                    w_lastMakeNext = r_frame[7:0];
                    w_heldNext     = 1'b1;
                    w_tickNext     = 1'b1;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_bitCnt   <= 4'd0;
            r_frame    <= 10'd0;
            r_toCnt    <= '0;
            r_brk      <= 1'b0;
            r_held     <= 1'b0;
            r_lastMake <= 8'h00;
            r_dato     <= 8'h00;
            r_tick     <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_bitCnt   <= w_bitCntNext;
            r_frame    <= w_frameNext;
            r_toCnt    <= w_toCntNext;
            r_brk      <= w_brkNext;
            r_held     <= w_heldNext;
            r_lastMake <= w_lastMakeNext;
            r_dato     <= w_datoNext;
            r_tick     <= w_tickNext;
            r_err      <= w_errNext;
            r_busy     <= (w_stateNext != IDLE);
        end
    end

    assign ps2.dato = r_dato;
    assign ps2.tick = r_tick;
    assign ps2.err  = r_err;
    assign ps2.busy = r_busy;
endmodule
